// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding a UART transmitter that has no busy flag.
// Bytes pushed from the store path are buffered. They are released as
// single-cycle write strobes spaced a fixed number of clock cycles apart, so
// the transmitter always finishes a frame before the next byte arrives.
module uart_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 9600
) (
    input  logic              sys_clk_i,
    input  logic              sys_rstn_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              ovf_clr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_n;
    logic              full_q;
    logic              empty_q;
    logic              ovf_q;
    logic              nempty_q;
    logic              uart_wr_q;
    logic [7:0]        uart_dat_q;
    state_t            state_q;
    state_t            state_n;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_n;
    logic              push;
    logic              pop;

    // A push is only taken when the registered count says there is room.
    assign push = wr_en_i & ~full_q;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_n = count_q;
        case ({push, pop})
            2'b10:   count_n = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_n = count_q - (ADDR_W + 1)'(1);
            default: count_n = count_q;
        endcase
    end

    // Pacing FSM: a strobe (and pop) in IDLE as soon as data is seen, then in
    // WAIT only when the gap counter has run down to zero.  Occupancy is seen
    // through nempty_q, one cycle behind count_q.  Pops are never on adjacent
    // edges, so nempty_q can lag a write but never claims data that is gone.
    always_comb begin
        state_n = state_q;
        gap_n   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (nempty_q) begin
                    pop     = 1'b1;
                    gap_n   = GAP_RELOAD;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (gap_q != '0) begin
                    gap_n = gap_q - GAP_W'(1);
                end else if (nempty_q) begin
                    pop   = 1'b1;
                    gap_n = GAP_RELOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state and gap counter.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            gap_q   <= gap_n;
        end
    end

    // FIFO pointers, occupancy and the status flags derived from it.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            nempty_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q  <= count_n;
            full_q   <= (count_n == FULL_CNT);
            empty_q  <= (count_n == '0);
            nempty_q <= (count_q != '0);
        end
    end

    // Sticky overflow: a dropped write wins over a clear in the same cycle.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && full_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Transmitter interface: strobe on the pop edge, data held between pops.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            uart_wr_q  <= 1'b0;
            uart_dat_q <= 8'h00;
        end else begin
            uart_wr_q <= pop;
            if (pop) begin
                uart_dat_q <= mem[rd_ptr_q];
            end
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign uart_wr_o  = uart_wr_q;
    assign uart_dat_o = uart_dat_q;

endmodule
